// File: rtl/piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_register
// Brief    : Parallel-in serial-out shifter, LSB first, zero fill after word.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_register #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_en,
    output logic                  dout
);

    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] w_sr_shifted;

    // A one-bit register has nothing above bit 0 to shift down, so it just clears.
    generate
        if (DATA_WIDTH == 1) begin : g_single_bit
            assign w_sr_shifted = 1'b0;
        end else begin : g_multi_bit
            assign w_sr_shifted = {1'b0, r_sr[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sr <= '0;
        end else if (din_en) begin
            r_sr <= din;
        end else begin
            r_sr <= w_sr_shifted;
        end
    end

    assign dout = r_sr[0];

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_shift_register
// Brief    : Self-checking bench; word/bit-index reference model plus literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_shift_register;

    localparam int DATA_WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic [DATA_WIDTH-1:0] din = '1;
    logic                  din_en = 1'b1;
    logic                  dout;

    piso_shift_register #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .din    (din),
        .din_en (din_en),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    // Reference: the last loaded word and the index of the bit now on the wire.
    logic [DATA_WIDTH-1:0] m_word = '0;
    int                    m_idx  = DATA_WIDTH;
    logic                  m_valid = 1'b0;
    logic                  m_exp;

    always @(posedge clk) begin
        if (!resetn) begin
            m_valid <= 1'b1;
            m_idx   <= DATA_WIDTH;
        end else if (din_en) begin
            m_word <= din;
            m_idx  <= 0;
        end else if (m_idx < DATA_WIDTH) begin
            m_idx <= m_idx + 1;
        end
    end

    assign m_exp = (m_idx < DATA_WIDTH) ? m_word[m_idx] : 1'b0;

    int    n_pass  = 0;
    int    n_total = 0;
    logic  lit_en  = 1'b0;
    logic  lit_exp = 1'b0;
    string lit_name = "";

    always @(negedge clk) begin
        if (m_valid) begin
            n_total++;
            if (dout === m_exp) n_pass++;
            else $display("FAIL model t=%0t dout=%b expected=%b", $time, dout, m_exp);
            if (lit_en) begin
                n_total++;
                if (dout === lit_exp) n_pass++;
                else $display("FAIL %s dout t=%0t got=%b expected=%b", lit_name, $time, dout, lit_exp);
                n_total++;
                if (m_exp === lit_exp) n_pass++;
                else $display("FAIL %s model t=%0t got=%b expected=%b", lit_name, $time, m_exp, lit_exp);
            end
        end
    end

    // Drive inputs for one edge; optionally pin dout after that edge to a literal.
    task automatic apply(input logic r, input logic e, input logic [DATA_WIDTH-1:0] d,
                         input logic chk, input logic exp_bit, input string name);
        resetn   = r;
        din_en   = e;
        din      = d;
        lit_en   = chk;
        lit_exp  = exp_bit;
        lit_name = name;
        @(posedge clk);
        @(negedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] pat;
        logic [DATA_WIDTH-1:0] words [5];
        words[0] = 16'h3524; words[1] = 16'h5E81; words[2] = 16'hD609;
        words[3] = 16'h5663; words[4] = 16'h7B0D;

        // Reset held with load requested
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "reset");
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "post_reset");

        // Single load, then din changing while not loaded
        pat = 16'h00FB;
        for (int pass = 0; pass < 2; pass++) begin
            apply(1'b1, 1'b1, 16'h00FB, 1'b1, pat[0], "load_bit0");
            for (int k = 1; k < DATA_WIDTH; k++)
                apply(1'b1, 1'b0, (pass == 0) ? 16'h0000 : 16'h0005, 1'b1, pat[k], "shift");
            for (int k = 0; k < 4; k++)
                apply(1'b1, 1'b0, (pass == 0) ? 16'h0000 : 16'h0005, 1'b1, 1'b0, "tail_zero");
        end

        // Reload mid-stream
        apply(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, "reload_a");
        apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, "reload_a");
        apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, "reload_a");
        apply(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "reload_b0");
        apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, "reload_b1");
        for (int k = 0; k < 16; k++) apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "reload_tail");

        // din_en held for five words
        apply(1'b1, 1'b1, words[0], 1'b1, 1'b0, "hold_load");
        apply(1'b1, 1'b1, words[1], 1'b1, 1'b1, "hold_load");
        apply(1'b1, 1'b1, words[2], 1'b1, 1'b1, "hold_load");
        apply(1'b1, 1'b1, words[3], 1'b1, 1'b1, "hold_load");
        apply(1'b1, 1'b1, words[4], 1'b1, 1'b1, "hold_load");
        pat = 16'h7B0D;
        for (int k = 1; k < DATA_WIDTH; k++) apply(1'b1, 1'b0, 16'h0000, 1'b1, pat[k], "hold_shift");
        apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "hold_tail");

        // Reset during shift
        apply(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, "rst_mid_load");
        for (int k = 0; k < 4; k++) apply(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, "rst_mid_shift");
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "rst_mid_reset");
        for (int k = 0; k < 18; k++) apply(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "rst_mid_after");

        // Gapless streaming: new word at the last-bit edge
        apply(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, "");
        for (int k = 1; k < DATA_WIDTH; k++) apply(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "");
        apply(1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, "gapless_b0");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 31) != 0), ($urandom_range(0, 5) == 0),
                  DATA_WIDTH'($urandom), 1'b0, 1'b0, "");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
